// File: rtl/ap3216_pkg.sv
// Shared definitions for the AP3216 ambient-light poll sequencer:
// register map, sequencer states and the I2C command fields.
package ap3216_pkg;

  localparam logic [7:0] SYS_CFG   = 8'h00;
  localparam logic [7:0] ALS_LO    = 8'h0C;
  localparam logic [7:0] ALS_HI    = 8'h0D;
  localparam logic [7:0] SWRST_VAL = 8'h04;

  typedef enum logic [3:0] {
    ST_SWRST_WR   = 4'd0,
    ST_SWRST_WAIT = 4'd1,
    ST_MODE_WR    = 4'd2,
    ST_CONV_WAIT  = 4'd3,
    ST_RD_LO      = 4'd4,
    ST_RD_HI      = 4'd5,
    ST_PUBLISH    = 4'd6,
    ST_POLL_WAIT  = 4'd7,
    ST_IDLE       = 4'd8
  } state_t;

  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } cmd_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ap3216_txn_timer.sv
// Loadable down-counter: a load of N raises O_done in the Nth cycle after the
// load edge, so a state that exits on O_done lasts exactly N cycles.
module ap3216_txn_timer #(
  parameter int W = 8
) (
  input  logic         I_clk,
  input  logic         I_reset,
  input  logic         I_load,
  input  logic [W-1:0] I_load_val,
  output logic         O_done
);

  logic [W-1:0] cnt_r;

  // Count down to zero and park there until the next load.
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      cnt_r <= {W{1'b0}};
    end else if (I_load) begin
      cnt_r <= I_load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign O_done = (cnt_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/ap3216_poll_sequencer.sv
// AP3216 bring-up and periodic ALS polling over a byte-level I2C master,
// with response timeout, bounded retries and full re-initialisation.
module ap3216_poll_sequencer
  import ap3216_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h1E,
  parameter logic [7:0] MODE_VAL       = 8'h01,
  parameter int         SWRST_WAIT     = 500_000,
  parameter int         CONV_WAIT      = 6_000_000,
  parameter int         POLL_CYCLES    = 5_000_000,
  parameter int         TIMEOUT_CYCLES = 100_000,
  parameter int         MAX_RETRY      = 3
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_enable,
  output logic        O_cmd_valid,
  input  logic        I_cmd_ready,
  output logic        O_cmd_rw,
  output logic [6:0]  O_cmd_dev,
  output logic [7:0]  O_cmd_reg,
  output logic [7:0]  O_cmd_wdata,
  input  logic        I_rsp_valid,
  input  logic        I_rsp_err,
  input  logic [7:0]  I_rsp_rdata,
  output logic [15:0] O_als_data,
  output logic [11:0] O_bright_data,
  output logic        O_als_valid,
  output logic        O_sensor_ok,
  output logic [7:0]  O_err_count
);

  localparam int TW = $clog2(max4(SWRST_WAIT, CONV_WAIT, POLL_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  state_t        state_r;
  cmd_t          cmd_r;
  logic          cmd_valid_r;
  logic          pending_r;
  logic [RW-1:0] retry_r;
  logic [7:0]    lo_r;
  logic [15:0]   als_data_r;
  logic          als_valid_r;
  logic          sensor_ok_r;
  logic [7:0]    err_count_r;

  logic          accept_s;
  logic          rsp_s;
  logic          ok_s;
  logic          fail_s;
  logic          tmr_load_s;
  logic [TW-1:0] tmr_val_s;
  logic          tmr_done_s;

  function automatic cmd_t cmd_for(input state_t s);
    cmd_t c;
    case (s)
      ST_SWRST_WR: c = '{1'b0, DEV_ADDR, SYS_CFG, SWRST_VAL};
      ST_MODE_WR:  c = '{1'b0, DEV_ADDR, SYS_CFG, MODE_VAL};
      ST_RD_LO:    c = '{1'b1, DEV_ADDR, ALS_LO, 8'h00};
      ST_RD_HI:    c = '{1'b1, DEV_ADDR, ALS_HI, 8'h00};
      default:     c = '{1'b0, 7'h00, 8'h00, 8'h00};
    endcase
    return c;
  endfunction

  // Handshake qualifiers and the single timer's load source; a response in
  // the expiry cycle masks the timeout.
  always_comb begin
    accept_s   = cmd_valid_r & I_cmd_ready;
    rsp_s      = pending_r & I_rsp_valid;
    ok_s       = rsp_s & ~I_rsp_err;
    fail_s     = (rsp_s & I_rsp_err) | (pending_r & ~I_rsp_valid & tmr_done_s);
    tmr_load_s = 1'b0;
    tmr_val_s  = {TW{1'b0}};
    if (accept_s) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = TW'(TIMEOUT_CYCLES);
    end else if (ok_s && (state_r == ST_SWRST_WR)) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = TW'(SWRST_WAIT);
    end else if (ok_s && (state_r == ST_MODE_WR)) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = TW'(CONV_WAIT);
    end else if (state_r == ST_PUBLISH) begin
      tmr_load_s = 1'b1;
      tmr_val_s  = TW'(POLL_CYCLES);
    end else begin
      tmr_load_s = 1'b0;
      tmr_val_s  = {TW{1'b0}};
    end
  end

  ap3216_txn_timer #(.W(TW)) u_timer (
    .I_clk      (I_clk),
    .I_reset    (I_reset),
    .I_load     (tmr_load_s),
    .I_load_val (tmr_val_s),
    .O_done     (tmr_done_s)
  );

  // Sequencer FSM; entering a command state raises O_cmd_valid on the same edge.
  always_ff @(posedge I_clk) begin
    if (!I_reset) begin
      state_r     <= ST_SWRST_WR;
      cmd_r       <= '{1'b0, 7'h00, 8'h00, 8'h00};
      cmd_valid_r <= 1'b0;
      pending_r   <= 1'b0;
      retry_r     <= {RW{1'b0}};
      lo_r        <= 8'h00;
      als_data_r  <= 16'h0000;
      als_valid_r <= 1'b0;
      sensor_ok_r <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      als_valid_r <= 1'b0;
      if (accept_s) begin
        cmd_valid_r <= 1'b0;
        pending_r   <= 1'b1;
      end
      case (state_r)
        ST_SWRST_WR, ST_MODE_WR, ST_RD_LO, ST_RD_HI: begin
          if (!cmd_valid_r && !pending_r) begin
            cmd_valid_r <= 1'b1;
            cmd_r       <= cmd_for(state_r);
          end else if (ok_s) begin
            pending_r <= 1'b0;
            case (state_r)
              ST_SWRST_WR: state_r <= ST_SWRST_WAIT;
              ST_MODE_WR:  state_r <= ST_CONV_WAIT;
              ST_RD_LO: begin
                lo_r        <= I_rsp_rdata;
                state_r     <= ST_RD_HI;
                cmd_valid_r <= 1'b1;
                cmd_r       <= cmd_for(ST_RD_HI);
              end
              ST_RD_HI: begin
                als_data_r  <= {I_rsp_rdata, lo_r};
                als_valid_r <= 1'b1;
                sensor_ok_r <= 1'b1;
                retry_r     <= {RW{1'b0}};
                state_r     <= ST_PUBLISH;
              end
              default: state_r <= ST_SWRST_WR;
            endcase
          end else if (fail_s) begin
            pending_r   <= 1'b0;
            err_count_r <= (err_count_r == 8'hFF) ? 8'hFF : err_count_r + 8'h01;
            cmd_valid_r <= 1'b1;
            if (retry_r < RETRY_LAST) begin
              retry_r <= retry_r + {{(RW-1){1'b0}}, 1'b1};
              // A half-read sample is discarded: the low byte is always re-read.
              if (state_r == ST_RD_HI) begin
                state_r <= ST_RD_LO;
                cmd_r   <= cmd_for(ST_RD_LO);
              end else begin
                state_r <= state_r;
                cmd_r   <= cmd_for(state_r);
              end
            end else begin
              retry_r     <= {RW{1'b0}};
              sensor_ok_r <= 1'b0;
              state_r     <= ST_SWRST_WR;
              cmd_r       <= cmd_for(ST_SWRST_WR);
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_SWRST_WAIT: begin
          if (tmr_done_s) begin
            state_r     <= ST_MODE_WR;
            cmd_valid_r <= 1'b1;
            cmd_r       <= cmd_for(ST_MODE_WR);
          end
        end
        ST_CONV_WAIT: begin
          if (tmr_done_s) begin
            state_r     <= ST_RD_LO;
            cmd_valid_r <= 1'b1;
            cmd_r       <= cmd_for(ST_RD_LO);
          end
        end
        ST_PUBLISH: state_r <= ST_POLL_WAIT;
        ST_POLL_WAIT: begin
          if (tmr_done_s && I_enable) begin
            state_r     <= ST_RD_LO;
            cmd_valid_r <= 1'b1;
            cmd_r       <= cmd_for(ST_RD_LO);
          end else if (tmr_done_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_POLL_WAIT;
          end
        end
        ST_IDLE: begin
          if (I_enable) begin
            state_r     <= ST_RD_LO;
            cmd_valid_r <= 1'b1;
            cmd_r       <= cmd_for(ST_RD_LO);
          end
        end
        default: begin
          state_r     <= ST_SWRST_WR;
          cmd_valid_r <= 1'b0;
          pending_r   <= 1'b0;
        end
      endcase
    end
  end

  assign O_cmd_valid   = cmd_valid_r;
  assign O_cmd_rw      = cmd_r.rw;
  assign O_cmd_dev     = cmd_r.dev;
  assign O_cmd_reg     = cmd_r.reg_addr;
  assign O_cmd_wdata   = cmd_r.wdata;
  assign O_als_data    = als_data_r;
  assign O_bright_data = als_data_r[15:4];
  assign O_als_valid   = als_valid_r;
  assign O_sensor_ok   = sensor_ok_r;
  assign O_err_count   = err_count_r;

endmodule

// File: tb/tb_ap3216_poll_sequencer.sv
// Directed bench for ap3216_poll_sequencer with shortened wait parameters;
// the bench plays the I2C master and checks every command and publish.
module tb_ap3216_poll_sequencer;

  localparam int SWRST = 10;
  localparam int CONV  = 20;
  localparam int POLL  = 50;
  localparam int TMO   = 30;

  logic        I_clk;
  logic        I_reset;
  logic        I_enable;
  logic        O_cmd_valid;
  logic        I_cmd_ready;
  logic        O_cmd_rw;
  logic [6:0]  O_cmd_dev;
  logic [7:0]  O_cmd_reg;
  logic [7:0]  O_cmd_wdata;
  logic        I_rsp_valid;
  logic        I_rsp_err;
  logic [7:0]  I_rsp_rdata;
  logic [15:0] O_als_data;
  logic [11:0] O_bright_data;
  logic        O_als_valid;
  logic        O_sensor_ok;
  logic [7:0]  O_err_count;

  int n_checks = 0;
  int n_fail   = 0;

  ap3216_poll_sequencer #(
    .DEV_ADDR       (7'h1E),
    .MODE_VAL       (8'h01),
    .SWRST_WAIT     (SWRST),
    .CONV_WAIT      (CONV),
    .POLL_CYCLES    (POLL),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (3)
  ) dut (
    .I_clk         (I_clk),
    .I_reset       (I_reset),
    .I_enable      (I_enable),
    .O_cmd_valid   (O_cmd_valid),
    .I_cmd_ready   (I_cmd_ready),
    .O_cmd_rw      (O_cmd_rw),
    .O_cmd_dev     (O_cmd_dev),
    .O_cmd_reg     (O_cmd_reg),
    .O_cmd_wdata   (O_cmd_wdata),
    .I_rsp_valid   (I_rsp_valid),
    .I_rsp_err     (I_rsp_err),
    .I_rsp_rdata   (I_rsp_rdata),
    .O_als_data    (O_als_data),
    .O_bright_data (O_bright_data),
    .O_als_valid   (O_als_valid),
    .O_sensor_ok   (O_sensor_ok),
    .O_err_count   (O_err_count)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a command, check it, optionally stall ready for 'hold' cycles, then accept it.
  task automatic do_cmd(input string tag, input logic rw, input logic [7:0] rg,
                        input logic [7:0] wd, input int hold, input int exp_wait);
    int waited;
    waited = 0;
    while (O_cmd_valid !== 1'b1 && waited < 400) begin
      @(negedge I_clk);
      waited++;
    end
    chk({tag, "_valid"}, {31'd0, O_cmd_valid}, 32'd1);
    if (O_cmd_valid === 1'b1) begin
      if (exp_wait >= 0) chk({tag, "_wait"}, waited, exp_wait);
      chk({tag, "_fields"}, {8'd0, O_cmd_rw, O_cmd_dev, O_cmd_reg, O_cmd_wdata},
          {8'd0, rw, 7'h1E, rg, wd});
      for (int i = 0; i < hold; i++) begin
        @(negedge I_clk);
        chk({tag, "_hold"}, {7'd0, O_cmd_valid, O_cmd_rw, O_cmd_dev, O_cmd_reg, O_cmd_wdata},
            {7'd0, 1'b1, rw, 7'h1E, rg, wd});
      end
      I_cmd_ready = 1'b1;
      @(negedge I_clk);
      I_cmd_ready = 1'b0;
      chk({tag, "_drop"}, {31'd0, O_cmd_valid}, 32'd0);
    end
  endtask

  task automatic respond(input logic err, input logic [7:0] rd);
    I_rsp_valid = 1'b1;
    I_rsp_err   = err;
    I_rsp_rdata = rd;
    @(negedge I_clk);
    I_rsp_valid = 1'b0;
    I_rsp_err   = 1'b0;
    I_rsp_rdata = 8'h00;
  endtask

  task automatic check_pub(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, {31'd0, O_als_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, O_als_data}, {16'd0, exp});
    chk({tag, "_bright"}, {20'd0, O_bright_data}, {20'd0, exp[15:4]});
    chk({tag, "_ok"}, {31'd0, O_sensor_ok}, 32'd1);
    @(negedge I_clk);
    chk({tag, "_pulse"}, {31'd0, O_als_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, {31'd0, O_cmd_valid}, 32'd0);
    chk({tag, "_cmd_fields"}, {8'd0, O_cmd_rw, O_cmd_dev, O_cmd_reg, O_cmd_wdata}, 32'd0);
    chk({tag, "_als"}, {4'd0, O_als_data, O_bright_data}, 32'd0);
    chk({tag, "_flags"}, {29'd0, O_als_valid, O_sensor_ok, 1'b0}, 32'd0);
    chk({tag, "_err"}, {24'd0, O_err_count}, 32'd0);
  endtask

  initial begin
    int stray;
    I_reset     = 1'b0;
    I_enable    = 1'b1;
    I_cmd_ready = 1'b0;
    I_rsp_valid = 1'b0;
    I_rsp_err   = 1'b0;
    I_rsp_rdata = 8'h00;
    repeat (3) @(negedge I_clk);
    check_reset_outputs("reset");
    I_reset = 1'b1;

    // Bring-up and first sample 0x1234.
    do_cmd("swrst", 1'b0, 8'h00, 8'h04, 0, -1);
    respond(1'b0, 8'h00);
    do_cmd("mode", 1'b0, 8'h00, 8'h01, 0, SWRST);
    respond(1'b0, 8'h00);
    do_cmd("rdlo1", 1'b1, 8'h0C, 8'h00, 0, CONV);
    respond(1'b0, 8'h34);
    do_cmd("rdhi1", 1'b1, 8'h0D, 8'h00, 0, 0);
    respond(1'b0, 8'h12);
    check_pub("pub1", 16'h1234);

    // Master stalls ready for 7 cycles on the next low-byte read.
    do_cmd("rdlo2", 1'b1, 8'h0C, 8'h00, 7, POLL);
    respond(1'b0, 8'h78);
    do_cmd("rdhi2", 1'b1, 8'h0D, 8'h00, 0, 0);
    respond(1'b0, 8'h56);
    check_pub("pub2", 16'h5678);
    chk("stall_err", {24'd0, O_err_count}, 32'd0);

    // High-byte NACK twice: each failure restarts at the low byte.
    do_cmd("rdlo3a", 1'b1, 8'h0C, 8'h00, 0, POLL);
    respond(1'b0, 8'h11);
    do_cmd("rdhi3a", 1'b1, 8'h0D, 8'h00, 0, 0);
    respond(1'b1, 8'h00);
    chk("nack1_err", {24'd0, O_err_count}, 32'd1);
    chk("nack1_hold", {15'd0, O_als_valid, O_als_data}, {15'd0, 1'b0, 16'h5678});
    do_cmd("rdlo3b", 1'b1, 8'h0C, 8'h00, 0, 0);
    respond(1'b0, 8'h22);
    do_cmd("rdhi3b", 1'b1, 8'h0D, 8'h00, 0, 0);
    respond(1'b1, 8'h00);
    chk("nack2_err", {24'd0, O_err_count}, 32'd2);
    do_cmd("rdlo3c", 1'b1, 8'h0C, 8'h00, 0, 0);
    respond(1'b0, 8'h33);
    do_cmd("rdhi3c", 1'b1, 8'h0D, 8'h00, 0, 0);
    respond(1'b0, 8'h44);
    check_pub("pub3", 16'h4433);
    chk("pub3_err", {24'd0, O_err_count}, 32'd2);

    // Three timeouts on the low-byte read force re-init (err 2 -> 5).
    do_cmd("rdlo4a", 1'b1, 8'h0C, 8'h00, 0, POLL);
    do_cmd("rdlo4b", 1'b1, 8'h0C, 8'h00, 0, TMO);
    chk("tmo1_err", {24'd0, O_err_count}, 32'd3);
    chk("tmo1_ok", {31'd0, O_sensor_ok}, 32'd1);
    do_cmd("rdlo4c", 1'b1, 8'h0C, 8'h00, 0, TMO);
    chk("tmo2_err", {24'd0, O_err_count}, 32'd4);
    do_cmd("swrst4", 1'b0, 8'h00, 8'h04, 0, TMO);
    chk("tmo3_err", {24'd0, O_err_count}, 32'd5);
    chk("tmo3_ok", {31'd0, O_sensor_ok}, 32'd0);
    chk("tmo3_hold", {16'd0, O_als_data}, 32'h4433);
    respond(1'b0, 8'h00);

    // Re-init, then drop enable while the high-byte read is outstanding.
    do_cmd("mode5", 1'b0, 8'h00, 8'h01, 0, SWRST);
    respond(1'b0, 8'h00);
    do_cmd("rdlo5", 1'b1, 8'h0C, 8'h00, 0, CONV);
    respond(1'b0, 8'hCD);
    do_cmd("rdhi5", 1'b1, 8'h0D, 8'h00, 0, 0);
    I_enable = 1'b0;
    respond(1'b0, 8'hAB);
    check_pub("pub5", 16'hABCD);
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge I_clk);
      if (O_cmd_valid !== 1'b0) stray++;
    end
    chk("idle_no_cmd", stray, 32'd0);
    I_enable = 1'b1;
    do_cmd("rdlo6", 1'b1, 8'h0C, 8'h00, 0, 1);

    // Reset with the read outstanding; the late response must be ignored.
    I_reset = 1'b0;
    repeat (2) @(negedge I_clk);
    check_reset_outputs("midreset");
    I_reset = 1'b1;
    respond(1'b0, 8'h99);
    do_cmd("swrst6", 1'b0, 8'h00, 8'h04, 0, -1);
    chk("late_rsp_state", {8'd0, O_err_count, O_als_data}, 32'd0);
    chk("late_rsp_ok", {31'd0, O_sensor_ok}, 32'd0);
    respond(1'b0, 8'h00);
    do_cmd("mode6", 1'b0, 8'h00, 8'h01, 0, SWRST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ap3216_poll_sequencer.md
Name: ap3216_poll_sequencer

Overview:
- Sequences the AP3216 ambient-light sensor over the shared byte-level I2C master (register-access command/response port).
- Flow: software reset, ALS-mode configuration, conversion wait, then periodic reads of ALS data registers 0x0C (low) and 0x0D (high).
- Publishes a 16-bit ALS sample plus a 12-bit brightness word to the brightness-smoothing logic.
- Owns error recovery: per-transaction timeout, bounded retries, full re-initialisation.

Parameters:
- DEV_ADDR, 7'h1E, AP3216 7-bit I2C address driven on O_cmd_dev.
- MODE_VAL, 8'h01, SYSTEM_CONFIG value (ALS only).
- SWRST_WAIT, 500_000, cycles after soft-reset write (10 ms at 50 MHz).
- CONV_WAIT, 6_000_000, cycles after mode write before first read (120 ms).
- POLL_CYCLES, 5_000_000, cycles from one publish to the next read (100 ms).
- TIMEOUT_CYCLES, 100_000, max cycles from command accept to response.
- MAX_RETRY, 3, consecutive failures before re-init.

Ports:
- I_clk  in  1  system clock, 50 MHz
- I_reset  in  1  synchronous active-low reset
- I_enable  in  1  polling enable
- O_cmd_valid  out  1  command request to I2C master
- I_cmd_ready  in  1  master accepts command
- O_cmd_rw  out  1  1=read, 0=write
- O_cmd_dev  out  7  device address
- O_cmd_reg  out  8  register address
- O_cmd_wdata  out  8  write data
- I_rsp_valid  in  1  one-cycle response pulse
- I_rsp_err  in  1  NACK/bus error, qualified by I_rsp_valid
- I_rsp_rdata  in  8  read data, qualified by I_rsp_valid
- O_als_data  out  16  latest ALS count
- O_bright_data  out  12  O_als_data[15:4]
- O_als_valid  out  1  one-cycle pulse on each publish
- O_sensor_ok  out  1  high after a successful read, low on init/re-init
- O_err_count  out  8  saturating total failure count

Behaviour:
- Clock and reset: one clock, I_clk. Reset I_reset is synchronous, active-low. All state updates on the I_clk rising edge.
- Reset values: state=SWRST_WR; O_cmd_valid=0; O_cmd_* =0; O_als_data=0; O_bright_data=0; O_als_valid=0; O_sensor_ok=0; O_err_count=0; all counters and retry count cleared.
- Reset mid-transaction: O_cmd_valid drops on the reset edge. A late response after reset is ignored, because no command is outstanding.
- Command handshake:
  - O_cmd_valid and O_cmd_* are held stable until the cycle where O_cmd_valid && I_cmd_ready; transfer occurs on that edge.
  - O_cmd_valid deasserts the next cycle. At most one command is outstanding.
  - Timeout counter starts at acceptance.
  - I_rsp_valid with nothing outstanding is ignored.
  - I_rsp_valid in the same cycle the timeout expires counts as a response; the response wins.
- States:
  - SWRST_WR: write reg 0x00 = 0x04. Success -> SWRST_WAIT.
  - SWRST_WAIT: count SWRST_WAIT cycles -> MODE_WR.
  - MODE_WR: write reg 0x00 = MODE_VAL. Success -> CONV_WAIT.
  - CONV_WAIT: count CONV_WAIT cycles -> RD_LO.
  - RD_LO: read 0x0C; latch low byte. Success -> RD_HI.
  - RD_HI: read 0x0D; success -> PUBLISH.
  - PUBLISH (1 cycle):
    - O_als_data = {hi, lo}; O_bright_data = {hi, lo}[15:4].
    - O_als_valid=1; O_sensor_ok=1; retry count cleared.
    - Go to POLL_WAIT.
  - POLL_WAIT: count POLL_CYCLES, then -> RD_LO if I_enable=1, else -> IDLE.
  - IDLE: O_cmd_valid=0; I_enable=1 -> RD_LO.
- Enable:
  - I_enable=0 during a transaction does not abort it; the sequence finishes through PUBLISH, then parks in IDLE.
  - Init states SWRST_WR..CONV_WAIT ignore I_enable.
- Failure (I_rsp_err=1 or timeout):
  - O_err_count increments, saturating at 255; retry count increments.
  - If retry count < MAX_RETRY, reissue the same command.
  - Otherwise clear retry count, O_sensor_ok=0, go to SWRST_WR.
  - O_als_data holds its last value on failure.
- Publish integrity: a sample is never published from mixed transactions. A failure in RD_HI restarts at RD_LO, not RD_HI.
- Latency: publish occurs 1 cycle after the RD_HI response edge.
- Counter widths: sized with $clog2 of the largest wait parameter + 1. Load value N gives exactly N cycles.

Decomposition:
- Shared package ap3216_pkg:
  - register addresses: SYS_CFG=8'h00, ALS_LO=8'h0C, ALS_HI=8'h0D;
  - SWRST_VAL=8'h04;
  - state enum;
  - command-field struct {rw, dev, reg, wdata}.
- Sub-module ap3216_txn_timer: a loadable down-counter with done flag, instantiated once. It is shared by the SWRST/CONV/POLL waits and the response timeout, because these are never active simultaneously.
- O_bright_data is driven combinationally from O_als_data.

Test Plan:
- Use reduced parameters: SWRST_WAIT=10, CONV_WAIT=20, POLL_CYCLES=50, TIMEOUT_CYCLES=30.
1. Release reset; BFM always ready, all responses ok, rdata 0x34 then 0x12 -> commands are W 0x00=0x04, W 0x00=0x01, R 0x0C, R 0x0D. Then O_als_data=16'h1234, O_bright_data=12'h123, a single O_als_valid pulse, O_sensor_ok=1.
2. Hold I_cmd_ready=0 for 7 cycles -> O_cmd_valid and fields stable for all 7 cycles. Exactly one transfer, and no timeout before acceptance.
3. BFM NACKs R 0x0D twice, then succeeds -> O_err_count=2. Reads restart at 0x0C after each failure, and one publish follows.
4. No response to R 0x0C for 30 cycles, three times -> O_err_count=3, O_sensor_ok=0, next command W 0x00=0x04.
5. Drop I_enable during RD_HI -> that sample still publishes; no further commands are issued. Re-raise I_enable -> R 0x0C within 1 cycle.
6. Assert I_reset while R 0x0C is outstanding, then deliver a late I_rsp_valid -> response ignored. Outputs at reset values; sequence restarts at W 0x00=0x04.
